// File: rtl/quadrature_encoder_emulator.sv
// Bus-programmable quadrature A/B generator: emits a programmed number of
// Gray-code steps at a programmed step period in either direction.
module quadrature_encoder_emulator #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    output logic        A,
    output logic        B
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_reg;
    logic [15:0] steps_reg;
    logic [15:0] period_reg;
    logic [15:0] remain_reg;
    logic [15:0] timer_reg;
    logic        dir_reg;
    logic        done_reg;
    logic        a_reg;
    logic        b_reg;
    logic [7:0]  data_out_reg;

    logic wr_en;
    logic rd_en;
    logic ctrl_wr;
    logic status_rd;
    logic busy;
    logic a_next;
    logic b_next;

    assign wr_en     = cs && wr;
    assign rd_en     = cs && rd;
    assign ctrl_wr   = wr_en && (addr == 16'h0005);
    assign status_rd = rd_en && (addr == 16'h0006);
    assign busy      = (state_reg == RUN);

    // Forward: A takes ~B, B takes A (A leads). Reverse is the mirror image.
    assign a_next = dir_reg ? b_reg  : ~b_reg;
    assign b_next = dir_reg ? ~a_reg : a_reg;

    assign A        = a_reg;
    assign B        = b_reg;
    assign data_out = data_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            steps_reg  <= 16'd0;
            period_reg <= DEFAULT_PERIOD;
            remain_reg <= 16'd0;
            timer_reg  <= 16'd0;
            dir_reg    <= 1'b0;
            done_reg   <= 1'b0;
            a_reg      <= 1'b0;
            b_reg      <= 1'b0;
        end else begin
            if (wr_en && addr == 16'h0001) steps_reg[7:0]   <= data_in;
            if (wr_en && addr == 16'h0002) steps_reg[15:8]  <= data_in;
            if (wr_en && addr == 16'h0003) period_reg[7:0]  <= data_in;
            if (wr_en && addr == 16'h0004) period_reg[15:8] <= data_in;

            // Later assignments below override this, so a same-edge set wins.
            if (status_rd) done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (ctrl_wr && data_in[0] && !data_in[2]) begin
                        if (steps_reg != 16'd0) begin
                            remain_reg <= steps_reg;
                            timer_reg  <= period_reg;
                            dir_reg    <= data_in[1];
                            done_reg   <= 1'b0;
                            state_reg  <= RUN;
                        end else begin
                            remain_reg <= 16'd0;
                            done_reg   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ctrl_wr && data_in[2]) begin
                        state_reg <= IDLE;
                    end else if (timer_reg != 16'd0) begin
                        timer_reg <= timer_reg - 16'd1;
                    end else begin
                        a_reg      <= a_next;
                        b_reg      <= b_next;
                        remain_reg <= remain_reg - 16'd1;
                        timer_reg  <= period_reg;
                        if (remain_reg == 16'd1) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data reflects register contents before this edge's updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg <= 8'h00;
        end else if (rd_en) begin
            case (addr)
                16'h0001: data_out_reg <= steps_reg[7:0];
                16'h0002: data_out_reg <= steps_reg[15:8];
                16'h0003: data_out_reg <= period_reg[7:0];
                16'h0004: data_out_reg <= period_reg[15:8];
                16'h0006: data_out_reg <= {4'b0000, done_reg, busy, a_reg, b_reg};
                16'h0007: data_out_reg <= remain_reg[7:0];
                16'h0008: data_out_reg <= remain_reg[15:8];
                default:  data_out_reg <= 8'h00;
            endcase
        end else begin
            data_out_reg <= 8'h00;
        end
    end

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for quadrature_encoder_emulator: bus register access, step
// timing, direction, STOP/restart, done semantics, loopback count, reset.
module tb_quadrature_encoder_emulator;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        cs;
    logic        rd;
    logic        wr;
    logic        A;
    logic        B;

    int vec_count;
    int err_count;
    int dec_count;
    int cnt_start;
    int p;
    logic [1:0] ab_prev;
    logic [1:0] seq [4];

    quadrature_encoder_emulator #(.DEFAULT_PERIOD(16'd999)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .data_out(data_out), .cs(cs), .rd(rd), .wr(wr), .A(A), .B(B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Reference decoder for the loopback count.
    always @(posedge clk) begin
        ab_prev <= {A, B};
        if ({A, B} != ab_prev) begin
            if (idx_of({A, B}) == ((idx_of(ab_prev) + 1) % 4)) dec_count <= dec_count + 1;
            else if (idx_of({A, B}) == ((idx_of(ab_prev) + 3) % 4)) dec_count <= dec_count - 1;
        end
    end

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        check_value(tag, 16'(data_out), 16'(exp));
    endtask

    // Checks {A,B} after every clock edge following a START write edge.
    task automatic check_run(input string tag, input int start_idx, input bit rev,
                             input int period, input int nsteps, input int ncycles,
                             input int inject, output int end_idx);
        int k;
        int idx;
        k = 0;
        idx = start_idx;
        for (int c = 1; c <= ncycles; c++) begin
            if (c == inject) begin
                cs = 1'b1; wr = 1'b1; addr = 16'h0005; data_in = 8'h03;
            end else begin
                cs = 1'b0; wr = 1'b0;
            end
            @(posedge clk);
            #1;
            if ((c % (period + 1)) == 0 && k < nsteps) k++;
            idx = (start_idx + (rev ? (4 * (nsteps + 1) - k) : k)) % 4;
            check_value($sformatf("%s_c%0d", tag, c), 16'({A, B}), 16'(seq[idx]));
            @(negedge clk);
        end
        cs = 1'b0; wr = 1'b0;
        end_idx = idx;
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        dec_count = 0;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ab", 16'({A, B}), 16'h0000);
        check_value("rst_dout", 16'(data_out), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("rst_per_lo", 16'h0003, 8'hE7);
        read_check("rst_per_hi", 16'h0004, 8'h03);
        read_check("rst_status", 16'h0006, 8'h00);
        read_check("rst_steps", 16'h0001, 8'h00);
        read_check("ctrl_read", 16'h0005, 8'h00);
        read_check("unmapped", 16'h0101, 8'h00);

        // Simultaneous read and write returns the pre-write value
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 16'h0001; data_in = 8'h55;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        check_value("rdwr_old", 16'(data_out), 16'h0000);
        read_check("rdwr_new", 16'h0001, 8'h55);

        // Forward 4 steps, period 2: edges at 3,6,9,12
        bus_write(16'h0001, 8'h04); bus_write(16'h0002, 8'h00);
        bus_write(16'h0003, 8'h02); bus_write(16'h0004, 8'h00);
        bus_write(16'h0005, 8'h01);
        check_run("fwd4", 0, 1'b0, 2, 4, 14, 0, p);
        read_check("fwd4_status", 16'h0006, 8'h08);
        read_check("fwd4_status2", 16'h0006, 8'h00);
        read_check("fwd4_remain", 16'h0007, 8'h00);

        // Reverse 3 steps, one per clock
        bus_write(16'h0001, 8'h03); bus_write(16'h0003, 8'h00);
        bus_write(16'h0005, 8'h03);
        check_run("rev3", p, 1'b1, 0, 3, 5, 0, p);
        read_check("rev3_remain", 16'h0007, 8'h00);
        read_check("rev3_status", 16'h0006, 8'h0A);

        // One reverse step back to phase 00
        bus_write(16'h0001, 8'h01);
        bus_write(16'h0005, 8'h03);
        check_run("rev1", p, 1'b1, 0, 1, 3, 0, p);
        read_check("rev1_status", 16'h0006, 8'h08);

        // 10 steps at period 5, STOP after the 4th step
        bus_write(16'h0001, 8'h0A); bus_write(16'h0003, 8'h05);
        bus_write(16'h0005, 8'h01);
        check_run("stop_run", p, 1'b0, 5, 10, 24, 0, p);
        bus_write(16'h0005, 8'h04);
        check_run("stop_hold", p, 1'b0, 5, 0, 20, 0, p);
        read_check("stop_rem_lo", 16'h0007, 8'h06);
        read_check("stop_rem_hi", 16'h0008, 8'h00);
        read_check("stop_status", 16'h0006, 8'h00);

        // Restart in reverse from the frozen phase
        bus_write(16'h0001, 8'h02); bus_write(16'h0003, 8'h01);
        bus_write(16'h0005, 8'h03);
        check_run("restart", p, 1'b1, 1, 2, 6, 0, p);
        read_check("restart_status", 16'h0006, 8'h0B);

        // START (reverse) written mid-run must be ignored
        bus_write(16'h0001, 8'h04); bus_write(16'h0003, 8'h02);
        bus_write(16'h0005, 8'h01);
        check_run("busy_start", p, 1'b0, 2, 4, 14, 5, p);
        read_check("busy_status", 16'h0006, 8'h0B);
        read_check("busy_status2", 16'h0006, 8'h03);

        // START with STEPS=0: no edges, done set
        bus_write(16'h0001, 8'h00); bus_write(16'h0002, 8'h00);
        bus_write(16'h0005, 8'h01);
        check_run("zero", p, 1'b0, 0, 0, 8, 0, p);
        read_check("zero_status", 16'h0006, 8'h0B);
        read_check("zero_remain", 16'h0007, 8'h00);

        // STATUS read on the edge that sets done: old value returned, set wins
        bus_write(16'h0001, 8'h01); bus_write(16'h0003, 8'h00);
        bus_write(16'h0005, 8'h01);
        read_check("race_old", 16'h0006, 8'h07);
        read_check("race_set", 16'h0006, 8'h09);
        read_check("race_clr", 16'h0006, 8'h01);

        // Loopback: 1000 forward steps at period 3
        bus_write(16'h0001, 8'hE8); bus_write(16'h0002, 8'h03);
        bus_write(16'h0003, 8'h03);
        cnt_start = dec_count;
        bus_write(16'h0005, 8'h01);
        repeat (4010) @(posedge clk);
        @(negedge clk);
        check_value("loop_count", 16'(dec_count - cnt_start), 16'd1000);
        read_check("loop_rem_lo", 16'h0007, 8'h00);
        read_check("loop_rem_hi", 16'h0008, 8'h00);
        read_check("loop_status", 16'h0006, 8'h09);

        // Asynchronous reset mid-run
        bus_write(16'h0001, 8'h64); bus_write(16'h0002, 8'h00);
        bus_write(16'h0003, 8'h01);
        bus_write(16'h0005, 8'h01);
        repeat (9) @(posedge clk);
        #1;
        check_value("pre_rst_ab", 16'({A, B}), 16'(2'b01));
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_ab", 16'({A, B}), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("rst2_status", 16'h0006, 8'h00);
        read_check("rst2_per_hi", 16'h0004, 8'h03);
        read_check("rst2_remain", 16'h0007, 8'h00);
        read_check("rst2_steps", 16'h0001, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
